data_mem_sync: RTL and testbench
================================

DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
- REQ-001: Parameter ADDR_W, default 32, byte-address width.
- REQ-002: Parameter DEPTH_WORDS, default 8192, number of 32-bit words; power of two.
- REQ-003: Parameter INIT_FILE, default "" (empty string), binary image loaded at elaboration; empty means no load.
- REQ-004: clk  in  1  single clock; all state updates on the rising edge.
- REQ-005: rst_n  in  1  reset, asynchronous assert, active-low.
- REQ-006: req  in  1  access request, sampled when ready=1.
- REQ-007: we  in  1  1=store, 0=load.
- REQ-008: size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- REQ-009: sign_ext  in  1  load sign-extension (lb/lh vs lbu/lhu); ignored for word and store.
- REQ-010: addr  in  ADDR_W  byte address.
- REQ-011: wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- REQ-012: ready  out  1  block can accept a request this cycle.
- REQ-013: rvalid  out  1  one-cycle completion pulse for every accepted request.
- REQ-014: rdata  out  32  load result, valid only while rvalid=1 and we of that request was 0.
- REQ-015: err  out  1  qualifies rvalid; 1 = request rejected, memory untouched.

Function
- REQ-016: Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
- REQ-017: FSM states IDLE, READ, RESP; ready=1 only in IDLE.
- REQ-018: IDLE with req=1 accepts the request and latches we, size, sign_ext, addr, wdata.
- REQ-019: Accepted illegal request -> RESP with err=1; illegal = size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[ADDR_W-1:2] >= DEPTH_WORDS.
- REQ-020: Accepted legal store -> byte lanes written at the accept edge using the lane mask (byte: 1 lane, half: lanes 2k,2k+1, word: all 4); -> RESP.
- REQ-021: Accepted legal load -> READ; array read registered at the READ edge; -> RESP.
- REQ-022: In RESP, rvalid=1 for exactly one cycle, then -> IDLE.
- REQ-023: Store latency: rvalid 1 cycle after accept. Load latency: rvalid 2 cycles after accept.
- REQ-024: Load alignment: selected byte/half shifted to bit 0. Upper bits are zero-filled when sign_ext=0, else replicate the MSB of the selected field.
- REQ-025: Outside RESP, and in RESP for stores or errors, rdata=0.
- REQ-026: req while ready=0 is ignored, not queued; the requester holds req until it sees ready.
- REQ-027: Back-to-back throughput: store every 2 cycles, load every 3 cycles.
- REQ-028: The array never drives X; unwritten, unloaded words read as 0.

Reset
- REQ-029: rst_n=0 forces state=IDLE, ready=1, rvalid=0, err=0, rdata=0 immediately, without waiting for clk.
- REQ-030: Memory array contents are not affected by reset.
- REQ-031: A store accepted before reset asserts is complete. A load or response in flight is discarded with no rvalid.
- REQ-032: The first request can be accepted on the first rising edge after rst_n deasserts.

Structure
- REQ-033: Shared package dmem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
- REQ-034: Sub-module dmem_lane_fmt (combinational) produces the 4-bit write mask, the lane-replicated write data, and the aligned/sign-extended load data.
- REQ-035: The array is one 32-bit-wide memory with per-byte write enables, inferable as block RAM.

Verification
- REQ-036: Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> first rvalid 1 cycle after accept, err=0; second rvalid 2 cycles after accept, rdata=0xDEADBEEF.
- REQ-037: Store byte 0x80 at 0x13, then load word at 0x10 -> 0x80ADBEEF. Byte load at 0x13 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080.
- REQ-038: Store half 0x1234 at 0x22, then load half at 0x22 -> 0x00001234. Word at 0x20 -> upper half 0x1234, lower half unchanged.
- REQ-039: Load word at 0x02, half at 0x01, size=11, and word at DEPTH_WORDS*4 -> each gives rvalid=1, err=1, rdata=0; memory unchanged.
- REQ-040: Assert rst_n=0 during READ of a load -> outputs at reset values asynchronously, no rvalid. Earlier store data still readable after reset.
- REQ-041: Hold req high continuously with 4 alternating stores/loads -> ready low exactly 1 cycle (store) / 2 cycles (load) after each accept; no request lost or duplicated.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings and FSM state shared by the data memory
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: byte-lane write mask/replication and load alignment with sign extension
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);
  logic [31:0] shifted;
  always_comb begin
    wmask     = size == SZ_WORD ? 4'hf : size == SZ_HALF ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
    wdata_rep = size == SZ_WORD ? wdata : size == SZ_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    shifted   = rword >> {lane, 3'b000};
    rdata     = size == SZ_BYTE ? {{24{sign_ext & shifted[7]}}, shifted[7:0]} :
                size == SZ_HALF ? {{16{sign_ext & shifted[15]}}, shifted[15:0]} : shifted;
  end
endmodule

// File: rtl/data_mem_sync.sv
// data_mem_sync: single-port byte-addressable data memory with request/response handshake
module data_mem_sync
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 8192,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_t          state, nxt;
  logic            we_q, sign_q, err_q, oob, illegal, accept, wr_en;
  logic [1:0]      size_q, lane_q, size_sel, lane_sel;
  logic [IW-1:0]   idx_q;
  logic [31:0]     rd_word, fmt_rdata, wdata_rep;
  logic [3:0]      wmask;
  logic [31:0]     mem [DEPTH_WORDS];
  if (ADDR_W > IW + 2) begin : g_oob
    assign oob = |addr[ADDR_W-1:IW+2];
  end else begin : g_no_oob
    assign oob = 1'b0;
  end
  always_comb begin
    illegal  = size == SZ_ILL || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00) || oob;
    accept   = state == IDLE && req;
    wr_en    = accept && we && !illegal && rst_n;
    size_sel = state == IDLE ? size : size_q;
    lane_sel = state == IDLE ? addr[1:0] : lane_q;
  end
  dmem_lane_fmt u_fmt (
    .size      (size_sel),
    .lane      (lane_sel),
    .sign_ext  (sign_q),
    .wdata     (wdata),
    .rword     (rd_word),
    .wmask     (wmask),
    .wdata_rep (wdata_rep),
    .rdata     (fmt_rdata)
  );
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'h0;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_en && wmask[i]) mem[addr[IW+1:2]][i*8 +: 8] <= wdata_rep[i*8 +: 8];
    if (state == READ) rd_word <= mem[idx_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      sign_q <= 1'b0;
      err_q  <= 1'b0;
      size_q <= SZ_BYTE;
      lane_q <= 2'b00;
      idx_q  <= '0;
    end else if (accept) begin
      we_q   <= we;
      sign_q <= sign_ext;
      err_q  <= illegal;
      size_q <= size;
      lane_q <= addr[1:0];
      idx_q  <= addr[IW+1:2];
    end
  end
  always_comb begin
    nxt = state == IDLE ? (req ? ((illegal || we) ? RESP : READ) : IDLE) : state == READ ? RESP : IDLE;
  end
  always_comb begin
    ready  = state == IDLE;
    rvalid = state == RESP;
    err    = rvalid && err_q;
    rdata  = (rvalid && !we_q && !err_q) ? fmt_rdata : 32'h0;
  end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: table-driven stimulus with a latency-aware response scoreboard
module tb_data_mem_sync;
  localparam int DEPTH = 256;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  logic clk = 0, rst_n = 0, req = 0, we = 0, sign_ext = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ready, rvalid, err;
  logic [31:0] rdata;
  int n_chk = 0, n_fail = 0, cyc = 0;
  exp_t sb[$];
  vec_t v[$];

  data_mem_sync #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(logic w, logic [1:0] s, logic x, logic [31:0] a, logic [31:0] d,
                              logic e, logic [31:0] r);
    vec_t t;
    t.we = w; t.size = s; t.sx = x; t.addr = a; t.wdata = d; t.err = e; t.rdata = r;
    return t;
  endfunction

  task automatic issue(input vec_t t, input bit hold);
    int n = 0;
    int d;
    while (!ready && n < 20) begin @(negedge clk); n++; end
    if (!ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_wait: ready stayed 0 for %0d cycles", n);
    end
    we = t.we; size = t.size; sign_ext = t.sx; addr = t.addr; wdata = t.wdata; req = 1;
    d = cyc + 1 + ((t.we || t.err) ? 0 : 1);
    @(posedge clk);
    sb.push_back('{t.err, t.rdata, d});
    if (!hold) begin
      #1 req = 0;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rvalid: rvalid=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("err", {31'b0, err}, {31'b0, e.err});
        chk("rdata", rdata, e.rdata);
      end
    end else begin
      chk("idle_rdata", rdata, 32'h0);
      chk("idle_err", {31'b0, err}, 32'h0);
      if (sb.size() != 0 && sb[0].due < cyc) begin
        e = sb.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missing_rvalid: response due at cycle %0d not seen by %0d", e.due, cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    v.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF));
    v.push_back(mk(1, 2'b00, 0, 32'h13, 32'h80, 0, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80ADBEEF));
    v.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFF80));
    v.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h00000080));
    v.push_back(mk(1, 2'b01, 0, 32'h22, 32'h1234, 0, 32'h0));
    v.push_back(mk(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'h00001234));
    v.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h12340000));
    v.push_back(mk(0, 2'b10, 0, 32'h02, 32'h0, 1, 32'h0));
    v.push_back(mk(0, 2'b01, 0, 32'h01, 32'h0, 1, 32'h0));
    v.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0));
    v.push_back(mk(0, 2'b10, 0, DEPTH * 4, 32'h0, 1, 32'h0));
    v.push_back(mk(1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 1, 32'h0));
    v.push_back(mk(1, 2'b10, 0, DEPTH * 4, 32'hFFFFFFFF, 1, 32'h0));
    v.push_back(mk(1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, 1, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80ADBEEF));
    v.push_back(mk(0, 2'b10, 0, 32'h00, 32'h0, 0, 32'h00000000));
    v.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0, 0, 32'hFFFF80AD));
    v.push_back(mk(0, 2'b00, 1, 32'h11, 32'h0, 0, 32'hFFFFFFBE));
    v.push_back(mk(0, 2'b01, 0, 32'h10, 32'h0, 0, 32'h0000BEEF));
    v.push_back(mk(1, 2'b01, 0, 32'h20, 32'hFFFFABCD, 0, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h1234ABCD));
    v.push_back(mk(1, 2'b00, 0, 32'h21, 32'hFFFFFF55, 0, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h123455CD));

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1;
    foreach (v[i]) issue(v[i], 0);

    // Reset pulled in the middle of a load: outputs drop at once and the load vanishes
    issue(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80ADBEEF), 0);
    #2 rst_n = 0;
    #1;
    chk("async_ready", {31'b0, ready}, 32'h1);
    chk("async_rvalid", {31'b0, rvalid}, 32'h0);
    chk("async_err", {31'b0, err}, 32'h0);
    chk("async_rdata", rdata, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h80ADBEEF), 0);

    // req held high across alternating stores and loads
    v.delete();
    v.push_back(mk(1, 2'b10, 0, 32'h40, 32'h11223344, 0, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h11223344));
    v.push_back(mk(1, 2'b00, 0, 32'h41, 32'hAA, 0, 32'h0));
    v.push_back(mk(0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h1122AA44));
    foreach (v[i]) begin
      issue(v[i], 1);
      n = 0;
      @(negedge clk);
      while (!ready && n < 10) begin n++; @(negedge clk); end
      chk(v[i].we ? "busy_store" : "busy_load", n, v[i].we ? 1 : 2);
    end
    req = 0;
    repeat (4) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
